fifo_rv_stream: RTL and testbench
=================================

FIFO_RV_STREAM -- requirements
Module: fifo_rv_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, memory entries; power of two, >=2.
REQ-003 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through, 0 = registered-output mode.
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-2, almost-full level threshold.
REQ-005 SHALL have parameter AE_THRESH, default 2, almost-empty level threshold.
REQ-006 SHALL define LW = $clog2(DEPTH)+2 as the width of level counts.
REQ-007 clk  input  1  clock; all state changes on rising edge.
REQ-008 clr  input  1  reset, asynchronous, active-low.
REQ-009 flush  input  1  synchronous discard of all stored entries.
REQ-010 clear_stats  input  1  synchronous restart of the peak-level watermark.
REQ-011 s_valid  input  1  write-side data valid.
REQ-012 s_ready  output  1  write-side space available.
REQ-013 s_data  input  DATA_WIDTH  write payload.
REQ-014 m_valid  output  1  read-side data valid.
REQ-015 m_ready  input  1  read-side consumer ready.
REQ-016 m_data  output  DATA_WIDTH  read payload.
REQ-017 level  output  LW  entries held, including the output register.
REQ-018 peak  output  LW  highest level since reset or clear_stats.
REQ-019 almost_full, almost_empty  output  1 each  threshold flags.

Function
REQ-020 Push SHALL occur when s_valid && s_ready at a rising edge; pop SHALL occur when m_valid && m_ready.
REQ-021 s_ready SHALL be a function of registered state only, never of m_ready or s_valid.
REQ-022 Capacity SHALL be DEPTH when FWFT=1 and DEPTH+1 when FWFT=0; s_ready = (level < capacity).
REQ-023 A push to a full FIFO SHALL NOT occur, even when a pop happens in the same cycle.
REQ-024 Data SHALL emerge in strict push order with no loss or duplication.
REQ-025 FWFT=1: m_valid SHALL rise on the edge that pushes into an empty FIFO (1-cycle latency); m_data = memory head.
REQ-026 FWFT=0: the head SHALL move from memory into an output register when that register is empty or being popped; first data visible 2 edges after push into an empty FIFO.
REQ-027 m_data SHALL be 0 whenever m_valid is 0, in both modes.
REQ-028 level SHALL be +1 on push-only, -1 on pop-only, and unchanged on simultaneous push+pop or idle.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH without a stall cycle.
REQ-030 almost_full = (level >= AF_THRESH); almost_empty = (level <= AE_THRESH); both decoded from the registered level.
REQ-031 peak SHALL update each edge to max(peak, next level).
REQ-032 clear_stats SHALL load peak with the next level, overriding REQ-031 in that cycle.
REQ-033 flush SHALL zero pointers, level and output-register valid on the next edge, overriding any same-cycle push or pop; peak SHALL be unaffected.
REQ-034 During flush, s_ready SHALL follow REQ-022 from the pre-flush level; a handshake in that cycle SHALL be discarded.

Reset
REQ-035 clr low SHALL immediately force pointers 0, level 0, peak 0, m_valid 0, m_data 0, s_ready 1, almost_full 0, almost_empty 1.
REQ-036 clr asserted mid-transfer SHALL discard all contents; operation SHALL resume on the first edge after clr rises.
REQ-037 Memory array contents SHALL NOT require reset.

Verification (DATA_WIDTH=8, DEPTH=4, AF_THRESH=3, AE_THRESH=1)
REQ-038 FWFT=1, push 0xA1..0xA4 back-to-back with m_ready=0 -> level 1,2,3,4; s_ready=0 after 4th edge; almost_full from level 3; peak=4.
REQ-039 FWFT=1, full, then s_valid=1 with data 0xB5 and m_ready=1 for one cycle -> 0xA1 popped, 0xB5 not accepted, level=3.
REQ-040 FWFT=0, push 0x11 into empty FIFO -> m_valid=1, m_data=0x11 two edges later; capacity 5 reached after 5 pushes.
REQ-041 Stream 20 words with s_valid=m_ready=1 continuously -> in-order output, level constant after fill, pointer wrap seen 5 times.
REQ-042 Level 3, assert flush together with push -> level 0, m_valid 0, peak still 3; then clear_stats -> peak 0.
REQ-043 Assert clr low mid-stream between edges -> outputs reach reset values of REQ-035 without a clock edge.

Source files
------------

// File: rtl/fifo_rv_stream.sv
// Ready/valid stream FIFO with selectable first-word-fall-through or registered output,
// plus level reporting, peak watermark and threshold flags.
module fifo_rv_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    localparam int LW        = $clog2(DEPTH) + 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  flush,
    input  logic                  clear_stats,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LW-1:0]         level,
    output logic [LW-1:0]         peak,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LW-1:0] CAP    = LW'((FWFT != 0) ? DEPTH : DEPTH + 1);
    localparam logic [LW-1:0] AF_LVL = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  rd_adv;
    logic [LW-1:0]         level_nxt;

    assign s_ready      = (level < CAP);
    assign push         = s_valid && s_ready;
    assign pop          = m_valid && m_ready;
    assign almost_full  = (level >= AF_LVL);
    assign almost_empty = (level <= AE_LVL);

    always_comb begin
        level_nxt = level;
        if (flush)
            level_nxt = '0;
        else
            level_nxt = level + LW'(push) - LW'(pop);
    end

    // Storage is never reset; validity is tracked purely by level and pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            peak   <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (rd_adv)
                    rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            if (clear_stats)
                peak <= level_nxt;
            else if (level_nxt > peak)
                peak <= level_nxt;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign m_valid = (level != '0);
            assign rd_adv  = pop;
            assign m_data  = m_valid ? mem[rd_ptr] : '0;
        end else begin : g_reg
            logic                  out_valid;
            logic [DATA_WIDTH-1:0] out_data;
            logic [LW-1:0]         mem_cnt;

            // Level counts the output register, so memory occupancy excludes it.
            assign mem_cnt = level - LW'(out_valid);
            assign rd_adv  = (mem_cnt != '0) && (!out_valid || pop);

            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else if (flush) begin
                    out_valid <= 1'b0;
                end else if (rd_adv) begin
                    out_valid <= 1'b1;
                    out_data  <= mem[rd_ptr];
                end else if (pop) begin
                    out_valid <= 1'b0;
                end
            end

            assign m_valid = out_valid;
            assign m_data  = out_valid ? out_data : '0;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_rv_stream.sv
// Checks a first-word-fall-through and a registered-output instance side by side
// against queue-based reference models, driven by directed and random steps.
module tb_fifo_rv_stream;

    localparam int LW = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       flush, clear_stats, s_valid, m_ready;
    logic [7:0] s_data;

    logic          s_ready0, m_valid0, af0, ae0;
    logic [7:0]    m_data0;
    logic [LW-1:0] level0, peak0;
    logic          s_ready1, m_valid1, af1, ae1;
    logic [7:0]    m_data1;
    logic [LW-1:0] level1, peak1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference models: FWFT instance is a plain queue; registered instance is a
    // memory queue plus a one-entry output slot.
    logic [7:0] q0[$];
    int         pk0;
    logic [7:0] mq1[$];
    bit         ov1;
    logic [7:0] od1;
    int         pk1;

    always #5 clk = ~clk;

    fifo_rv_stream #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .AF_THRESH(3), .AE_THRESH(1)) u_fwft (
        .clk(clk), .clr(clr), .flush(flush), .clear_stats(clear_stats),
        .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
        .level(level0), .peak(peak0), .almost_full(af0), .almost_empty(ae0)
    );

    fifo_rv_stream #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(0), .AF_THRESH(3), .AE_THRESH(1)) u_reg (
        .clk(clk), .clr(clr), .flush(flush), .clear_stats(clear_stats),
        .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
        .level(level1), .peak(peak1), .almost_full(af1), .almost_empty(ae1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int l0, l1;
        l0 = q0.size();
        l1 = mq1.size() + int'(ov1);
        chk("fwft_s_ready", 32'(s_ready0), 32'(l0 < 4));
        chk("fwft_m_valid", 32'(m_valid0), 32'(l0 > 0));
        chk("fwft_m_data",  32'(m_data0),  (l0 > 0) ? 32'(q0[0]) : 32'd0);
        chk("fwft_level",   32'(level0),   32'(l0));
        chk("fwft_peak",    32'(peak0),    32'(pk0));
        chk("fwft_af",      32'(af0),      32'(l0 >= 3));
        chk("fwft_ae",      32'(ae0),      32'(l0 <= 1));
        chk("reg_s_ready",  32'(s_ready1), 32'(l1 < 5));
        chk("reg_m_valid",  32'(m_valid1), 32'(ov1));
        chk("reg_m_data",   32'(m_data1),  ov1 ? 32'(od1) : 32'd0);
        chk("reg_level",    32'(level1),   32'(l1));
        chk("reg_peak",     32'(peak1),    32'(pk1));
        chk("reg_af",       32'(af1),      32'(l1 >= 3));
        chk("reg_ae",       32'(ae1),      32'(l1 <= 1));
    endtask

    task automatic model_reset();
        q0.delete();
        pk0 = 0;
        mq1.delete();
        ov1 = 1'b0;
        od1 = 8'h00;
        pk1 = 0;
    endtask

    task automatic step(input logic sv, input logic [7:0] sd, input logic mr,
                        input logic fl, input logic cs);
        bit push0, pop0, push1, pop1, ld1;
        int nl;
        s_valid     = sv;
        s_data      = sd;
        m_ready     = mr;
        flush       = fl;
        clear_stats = cs;
        push0 = sv && (q0.size() < 4);
        pop0  = mr && (q0.size() > 0);
        push1 = sv && ((mq1.size() + int'(ov1)) < 5);
        pop1  = mr && ov1;
        ld1   = (mq1.size() > 0) && (!ov1 || pop1);
        @(posedge clk);
        @(negedge clk);
        if (fl) begin
            q0.delete();
        end else begin
            if (pop0) void'(q0.pop_front());
            if (push0) q0.push_back(sd);
        end
        nl  = q0.size();
        pk0 = cs ? nl : ((nl > pk0) ? nl : pk0);
        if (fl) begin
            mq1.delete();
            ov1 = 1'b0;
        end else begin
            if (pop1) ov1 = 1'b0;
            if (ld1) begin
                od1 = mq1.pop_front();
                ov1 = 1'b1;
            end
            if (push1) mq1.push_back(sd);
        end
        nl  = mq1.size() + int'(ov1);
        pk1 = cs ? nl : ((nl > pk1) ? nl : pk1);
        check_all();
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0; clear_stats = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        clr = 1'b1;

        // Fill with A1..A4, consumer stalled
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0, 1'b0);
        // Offer B5 while popping: full FWFT instance must refuse it
        step(1'b1, 8'hB5, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Registered-output latency, then fill to capacity 5
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Continuous streaming of 20 words
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Flush with concurrent push, then restart watermark
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Random traffic with occasional flush and stats restart
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, $urandom_range(0, 30) == 0);

        // Asynchronous reset between edges while data is held
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        #2;
        clr = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 1) != 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
